// File: rtl/cursor_move_ctrl.sv
// Cursor tile sequencer: validates keyboard moves against the 10x6 tile map,
// commits legal moves on a frame boundary, then holds off input for a terrain cooldown.
module cursor_move_ctrl #(
  parameter int unsigned START_H  = 1,
  parameter int unsigned START_V  = 1,
  parameter int unsigned PATH_CD  = 4,
  parameter int unsigned WATER_CD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  output logic       key_ready,
  input  logic       frame_start,
  output logic [3:0] curAh,
  output logic [3:0] curAv,
  output logic       move_ok,
  output logic       move_blocked,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StCheck, StWaitFrame, StCooldown} state_e;

  state_e     state_q, state_d;
  logic [1:0] dir_q;
  logic [3:0] tgt_h_q, tgt_v_q, tgt_cd_q;
  logic [3:0] cd_q;
  logic [4:0] th, tv;
  logic       t_water, t_legal;
  logic       commit, blocked;

  // 5-bit arithmetic: stepping below 0 wraps to 31, which the range check rejects.
  always_comb begin
    th = {1'b0, curAh};
    tv = {1'b0, curAv};
    unique case (dir_q)
      2'd0: tv = {1'b0, curAv} - 5'd1;
      2'd1: tv = {1'b0, curAv} + 5'd1;
      2'd2: th = {1'b0, curAh} - 5'd1;
      2'd3: th = {1'b0, curAh} + 5'd1;
      default: ;
    endcase
    t_water = (th % 5'd3) == 5'd0;
    t_legal = (th <= 5'd9) && (tv <= 5'd5) && (t_water || (tv[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    blocked = 1'b0;
    unique case (state_q)
      StIdle: if (key_valid) state_d = StCheck;
      StCheck: begin
        if (t_legal) begin
          state_d = StWaitFrame;
        end else begin
          state_d = StIdle;
          blocked = 1'b1;
        end
      end
      StWaitFrame: begin
        if (frame_start) begin
          commit  = 1'b1;
          state_d = (tgt_cd_q == 4'd0) ? StIdle : StCooldown;
        end
      end
      StCooldown: if (frame_start && cd_q == 4'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dir_q        <= 2'd0;
      tgt_h_q      <= 4'd0;
      tgt_v_q      <= 4'd0;
      tgt_cd_q     <= 4'd0;
      cd_q         <= 4'd0;
      curAh        <= 4'(START_H);
      curAv        <= 4'(START_V);
      move_ok      <= 1'b0;
      move_blocked <= 1'b0;
      key_ready    <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_ok      <= commit;
      move_blocked <= blocked;
      key_ready    <= (state_d == StIdle);
      busy         <= (state_d != StIdle);
      if (state_q == StIdle && key_valid) dir_q <= key_dir;
      if (state_q == StCheck) begin
        tgt_h_q  <= th[3:0];
        tgt_v_q  <= tv[3:0];
        tgt_cd_q <= t_water ? 4'(WATER_CD) : 4'(PATH_CD);
      end
      // The committing frame_start loads the counter; later ones count it down.
      if (commit) begin
        curAh <= tgt_h_q;
        curAv <= tgt_v_q;
        cd_q  <= tgt_cd_q;
      end else if (state_q == StCooldown && frame_start) begin
        cd_q <= cd_q - 4'd1;
      end
    end
  end

endmodule

// File: doc/cursor_move_ctrl.md
Name: cursor_move_ctrl

Overview:
- Sequences the player cursor tile position (curAh, curAv) consumed by the VGA pixel generator on the 10x6 tile map (64-pixel tiles).
- Accepts direction events from the keyboard decoder over a valid/ready handshake and checks the target tile against the map rules.
- Commits legal moves only on a frame boundary, so the cursor never tears mid-frame, then enforces a per-terrain cooldown counted in frames.

Parameters:
- START_H, 1, reset column of cursor (must be a PATH tile)
- START_V, 1, reset row of cursor
- PATH_CD, 4, cooldown frames after entering a PATH tile (0..15)
- WATER_CD, 8, cooldown frames after entering a WATER tile (0..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  direction event available; source holds it and key_dir stable until accepted
- key_dir  in  2  0=up (v-1), 1=down (v+1), 2=left (h-1), 3=right (h+1)
- key_ready  out  1  block can accept an event
- frame_start  in  1  one-cycle pulse from VGA sync at start of each frame
- curAh  out  4  cursor column 0..9, to pixel generator
- curAv  out  4  cursor row 0..5, to pixel generator
- move_ok  out  1  one-cycle pulse: move committed
- move_blocked  out  1  one-cycle pulse: move rejected
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): curAh=START_H, curAv=START_V, state=IDLE, key_ready=1, move_ok=0, move_blocked=0, busy=0, cooldown counter=0.
- All outputs are registered. key_ready=1 exactly when state==IDLE. busy is the inverse of key_ready.
- Tile classes for in-range (h,v):
  - WATER if h%3==0.
  - else BLOCK if v%4==0.
  - else PATH.
- Legal target: 0<=h<=9, 0<=v<=5, and class != BLOCK. Arithmetic uses 5-bit signed/extended compares: h-1 from 0 and v-1 from 0 are out of range (no wrap); h+1 from 9 and v+1 from 5 are out of range.
- FSM:
  - IDLE: on key_valid&&key_ready, latch key_dir and go to CHECK.
  - CHECK (exactly 1 cycle): compute target and class.
    - Illegal: go to IDLE. move_blocked=1 for the single cycle in which the block is back in IDLE; cursor unchanged.
    - Legal: latch target and class, go to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, go to COOLDOWN (or IDLE if the loaded cooldown is 0).
    - In the next cycle curAh/curAv show the target and move_ok=1 for one cycle.
    - Cooldown loads WATER_CD if the target is WATER, else PATH_CD.
  - COOLDOWN: each frame_start decrements the counter. A frame_start with counter==1 goes to IDLE.
- Latency:
  - Blocked move: accept at cycle t; move_blocked and key_ready=1 at t+2.
  - Legal move: cursor updates the cycle after the first frame_start that occurs while in WAIT_FRAME.
  - A frame_start seen in CHECK is ignored; the block waits for the next one.
- The frame_start that commits a move does not count toward cooldown. key_ready returns on the cycle after the N-th subsequent frame_start.
- key_valid while not ready: ignored with no side effects. The source holds it, so it is accepted on the first IDLE cycle.
- Back-to-back: if key_valid is already high when the block re-enters IDLE, it is accepted in that same cycle.
- Reset mid-operation (any state): immediate return to reset values. A pending latched move is discarded, and no move_ok or move_blocked pulse is emitted.
- move_ok and move_blocked are never high in the same cycle.

Test Plan:
- Reset: assert rst_n=0 asynchronously, no clock edge -> curAh=1, curAv=1, key_ready=1, busy=0, pulses 0.
- Right from (1,1) to (2,1) PATH: frame_start 10 cycles later -> next cycle cur=(2,1), move_ok=1 for 1 cycle. key_ready stays 0 until the cycle after the 4th following frame_start.
- Left from (1,1) to (0,1) WATER -> cur=(0,1) after frame_start, cooldown 8 frames before key_ready=1.
- Up from (1,1) to (1,0) BLOCK, accepted at cycle t -> move_blocked=1 at t+2, key_ready=1 at t+2, cur=(1,1), no dependence on frame_start.
- Boundaries: at (0,1) press left -> blocked. Drive to (9,5) (WATER) and press down or right -> blocked. Cursor never shows h>9 or v>5.
- Reset in WAIT_FRAME (legal right pending), then a frame_start arrives -> cur stays (1,1), no move_ok, key_ready=1.
